// File: rtl/bus_responder_mem_if.sv
// rtl/bus_responder_mem_if.sv - t8086 minimum-mode bus signals between CPU and a memory responder
interface bus_responder_mem_if;
    logic        ale;
    logic [15:0] ad_i;
    logic [3:0]  as_i;
    logic        rd_n;
    logic        wr_n;
    logic        m_n;
    logic        bhe_n;
    logic        inta_n;
    logic [15:0] ad_o;
    logic        ad_oe;
    logic        rdy;

    modport master (
        output ale, ad_i, as_i, rd_n, wr_n, m_n, bhe_n, inta_n,
        input  ad_o, ad_oe, rdy
    );

    modport slave (
        input  ale, ad_i, as_i, rd_n, wr_n, m_n, bhe_n, inta_n,
        output ad_o, ad_oe, rdy
    );
endinterface

// File: rtl/bus_responder_mem.sv
// rtl/bus_responder_mem.sv - t8086 memory-space bus responder with RAM window and wait states
module bus_responder_mem #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [19:0] BASE      = 20'h00000,
    parameter int unsigned WAIT      = 2,
    parameter logic        MEM_SPACE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bus_responder_mem_if.slave bus
);
    localparam int unsigned WORDS = 2 ** (ADDR_W - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAITS, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                bhe_q, bhe_d;
    logic                dir_rd_q, dir_rd_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [15:0]         ad_o_q, ad_o_d;
    logic                ad_oe_q, ad_oe_d;

    // Even bank holds A0=0 bytes (low lane), odd bank holds A0=1 bytes (high lane)
    logic [7:0]          mem_even_q [WORDS];
    logic [7:0]          mem_odd_q  [WORDS];

    logic [19:0]         bus_addr;
    logic                sel;
    logic [ADDR_W-2:0]   widx;
    logic [15:0]         rd_word;
    logic                load_rd;
    logic                we_even;
    logic                we_odd;

    // Only the window bits above ADDR_W take part in decode; the rest index the RAM
    assign bus_addr = {bus.as_i, bus.ad_i};
    assign sel      = (bus_addr[19:ADDR_W] == BASE[19:ADDR_W]) && (bus.m_n == MEM_SPACE) && bus.inta_n;
    assign widx     = addr_q[ADDR_W-1:1];
    assign rd_word  = {bhe_q ? 8'h00 : mem_odd_q[widx], addr_q[0] ? 8'h00 : mem_even_q[widx]};

    // Next-state and output decode; ale restarts the cycle from any state
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        bhe_d    = bhe_q;
        dir_rd_d = dir_rd_q;
        wcnt_d   = wcnt_q;
        ad_o_d   = ad_o_q;
        ad_oe_d  = ad_oe_q;
        load_rd  = 1'b0;
        we_even  = 1'b0;
        we_odd   = 1'b0;
        if (bus.ale) begin
            addr_d  = bus_addr[ADDR_W-1:0];
            bhe_d   = bus.bhe_n;
            state_d = sel ? ADDR : IDLE;
            ad_oe_d = 1'b0;
            ad_o_d  = 16'h0000;
        end else begin
            case (state_q)
                ADDR: begin
                    if (!bus.rd_n && !bus.wr_n) begin
                        state_d = IDLE;
                    end else if (!bus.rd_n || !bus.wr_n) begin
                        dir_rd_d = !bus.rd_n;
                        wcnt_d   = 4'(WAIT);
                        if (WAIT == 0) begin
                            state_d = ACCESS;
                            load_rd = !bus.rd_n;
                        end else begin
                            state_d = WAITS;
                        end
                    end
                end
                WAITS: begin
                    // A strobe withdrawn before ACCESS abandons the cycle without a commit
                    if (bus.rd_n && bus.wr_n) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                        if (wcnt_q == 4'd1) begin
                            state_d = ACCESS;
                            load_rd = dir_rd_q;
                        end
                    end
                end
                ACCESS: begin
                    state_d = DONE;
                    we_even = !dir_rd_q && !addr_q[0];
                    we_odd  = !dir_rd_q && !bhe_q;
                end
                DONE: begin
                    if (bus.rd_n && bus.wr_n) begin
                        state_d = IDLE;
                        ad_oe_d = 1'b0;
                        ad_o_d  = 16'h0000;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (load_rd) begin
            ad_o_d  = rd_word;
            ad_oe_d = 1'b1;
        end
    end

    // Control and read-data registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            bhe_q    <= 1'b1;
            dir_rd_q <= 1'b0;
            wcnt_q   <= 4'd0;
            ad_o_q   <= 16'h0000;
            ad_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            bhe_q    <= bhe_d;
            dir_rd_q <= dir_rd_d;
            wcnt_q   <= wcnt_d;
            ad_o_q   <= ad_o_d;
            ad_oe_q  <= ad_oe_d;
        end
    end

    // Per-lane write commit on the edge leaving ACCESS; a coinciding reset suppresses it
    always_ff @(posedge clk) begin
        if (rst && we_even) begin
            mem_even_q[widx] <= bus.ad_i[7:0];
        end
        if (rst && we_odd) begin
            mem_odd_q[widx] <= bus.ad_i[15:8];
        end
    end

    assign bus.ad_o  = ad_o_q;
    assign bus.ad_oe = ad_oe_q;
    assign bus.rdy   = (state_q != WAITS);
endmodule

// File: tb/tb_bus_responder_mem.sv
// tb/tb_bus_responder_mem.sv - checks bus_responder_mem with WAIT=2 and WAIT=0 against a transaction model
module tb_bus_responder_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        m_n;
    logic        bhe_n;
    logic        inta_n;
    logic [15:0] ad_i;
    logic [3:0]  as_i;

    always #5 clk = ~clk;

    bus_responder_mem_if bus_w2();
    bus_responder_mem_if bus_w0();

    assign bus_w2.ale = ale;    assign bus_w0.ale = ale;
    assign bus_w2.ad_i = ad_i;  assign bus_w0.ad_i = ad_i;
    assign bus_w2.as_i = as_i;  assign bus_w0.as_i = as_i;
    assign bus_w2.rd_n = rd_n;  assign bus_w0.rd_n = rd_n;
    assign bus_w2.wr_n = wr_n;  assign bus_w0.wr_n = wr_n;
    assign bus_w2.m_n = m_n;    assign bus_w0.m_n = m_n;
    assign bus_w2.bhe_n = bhe_n; assign bus_w0.bhe_n = bhe_n;
    assign bus_w2.inta_n = inta_n; assign bus_w0.inta_n = inta_n;

    bus_responder_mem #(.ADDR_W(12), .BASE(20'h00000), .WAIT(2), .MEM_SPACE(1'b1))
        u_dut_w2 (.clk(clk), .rst(rst), .bus(bus_w2));
    bus_responder_mem #(.ADDR_W(12), .BASE(20'h00000), .WAIT(0), .MEM_SPACE(1'b1))
        u_dut_w0 (.clk(clk), .rst(rst), .bus(bus_w0));

    int          n_vec = 0;
    int          n_bad = 0;
    bit          check_en = 1'b0;
    logic        exp_rdy [2];
    logic        exp_oe  [2];
    logic [15:0] exp_do  [2];
    int          wait_of [2] = '{2, 0};
    logic [7:0]  ref_mem [4096];

    int          lit_seq = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [15:0] lit_act;
    logic [15:0] lit_exp;

    // Per-cycle compare of both responders against the model, plus queued literal checks
    always @(negedge clk) begin
        logic        r, o;
        logic [15:0] v;
        int          add_v, add_b;
        add_v = 0;
        add_b = 0;
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                r = (d == 0) ? bus_w2.rdy   : bus_w0.rdy;
                o = (d == 0) ? bus_w2.ad_oe : bus_w0.ad_oe;
                v = (d == 0) ? bus_w2.ad_o  : bus_w0.ad_o;
                add_v++;
                if (r !== exp_rdy[d] || o !== exp_oe[d] || v !== exp_do[d]) begin
                    add_b++;
                    $display("FAIL cycle_wait%0d t=%0t: got rdy=%b ad_oe=%b ad_o=%h, required rdy=%b ad_oe=%b ad_o=%h",
                             wait_of[d], $time, r, o, v, exp_rdy[d], exp_oe[d], exp_do[d]);
                end
            end
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            add_v++;
            if (lit_act !== lit_exp) begin
                add_b++;
                $display("FAIL %s: got %h, required %h", lit_name, lit_act, lit_exp);
            end
        end
        n_vec <= n_vec + add_v;
        n_bad <= n_bad + add_b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = 1'b1;
            exp_oe[d]  = 1'b0;
            exp_do[d]  = 16'h0000;
        end
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_read(input logic [19:0] a, input logic bhe);
        logic [11:0] ev, od;
        ev = {a[11:1], 1'b0};
        od = {a[11:1], 1'b1};
        return {bhe ? 8'h00 : ref_mem[od], a[0] ? 8'h00 : ref_mem[ev]};
    endfunction

    // kind: 0 read, 1 write, 2 both strobes (protocol violation); strobe held for four edges
    task automatic bus_cycle(input logic [19:0] addr, input logic m, input logic bhe, input logic inta,
                             input int kind, input logic [15:0] wdata, input bit release_end,
                             output logic [15:0] rd_w2, output logic [15:0] rd_w0,
                             output int low_w2, output int low_w0);
        bit          hit, active;
        logic [15:0] rv;
        hit    = (addr[19:12] == 8'h00) && m && inta;
        active = hit && (kind != 2);
        ale = 1'b1; as_i = addr[19:16]; ad_i = addr[15:0];
        m_n = m; bhe_n = bhe; inta_n = inta;
        step();
        idle_exp();
        ale  = 1'b0;
        rd_n = !(kind == 0 || kind == 2);
        wr_n = !(kind == 1 || kind == 2);
        ad_i = (kind == 0) ? 16'h0000 : wdata;
        rv   = model_read(addr, bhe);
        low_w2 = 0;
        low_w0 = 0;
        for (int j = 0; j < 4; j++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                exp_rdy[d] = !(active && j < wait_of[d]);
                exp_oe[d]  = active && kind == 0 && j >= wait_of[d];
                exp_do[d]  = exp_oe[d] ? rv : 16'h0000;
            end
            if (!bus_w2.rdy) low_w2++;
            if (!bus_w0.rdy) low_w0++;
        end
        rd_w2 = bus_w2.ad_o;
        rd_w0 = bus_w0.ad_o;
        if (active && kind == 1) begin
            if (!addr[0]) ref_mem[{addr[11:1], 1'b0}] = wdata[7:0];
            if (!bhe)     ref_mem[{addr[11:1], 1'b1}] = wdata[15:8];
        end
        if (release_end) begin
            rd_n = 1'b1;
            wr_n = 1'b1;
            step();
            idle_exp();
        end
    endtask

    initial begin
        logic [15:0] r2, r0;
        int          l2, l0;
        rst = 1'b0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; m_n = 1'b1;
        bhe_n = 1'b1; inta_n = 1'b1; ad_i = 16'h0000; as_i = 4'h0;
        idle_exp();
        step();
        step();
        check_en = 1'b1;
        lit("reset_rdy", {15'h0, bus_w2.rdy}, 16'h0001);
        lit("reset_ad_oe", {15'h0, bus_w2.ad_oe}, 16'h0000);
        lit("reset_ad_o", bus_w2.ad_o, 16'h0000);
        rst = 1'b1;
        step();

        bus_cycle(20'h00010, 1'b1, 1'b0, 1'b1, 1, 16'hBEEF, 1'b1, r2, r0, l2, l0);
        lit("write_rdy_low_wait2", 16'(l2), 16'd2);
        lit("write_rdy_low_wait0", 16'(l0), 16'd0);
        bus_cycle(20'h00010, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("read_beef_wait2", r2, 16'hBEEF);
        lit("read_beef_wait0", r0, 16'hBEEF);
        lit("read_rdy_low_wait2", 16'(l2), 16'd2);
        lit("read_rdy_low_wait0", 16'(l0), 16'd0);
        bus_cycle(20'h00010, 1'b1, 1'b1, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("read_low_lane_only", r2, 16'h00EF);
        bus_cycle(20'h00011, 1'b1, 1'b1, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("read_no_lanes", r2, 16'h0000);

        bus_cycle(20'h00020, 1'b1, 1'b0, 1'b1, 1, 16'h1234, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h00021, 1'b1, 1'b0, 1'b1, 1, 16'h5A00, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h00020, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("byte_lane_wait2", r2, 16'h5A34);
        lit("byte_lane_wait0", r0, 16'h5A34);

        bus_cycle(20'h00FFE, 1'b1, 1'b0, 1'b1, 1, 16'hA55A, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h00FFE, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("top_of_window", r2, 16'hA55A);

        bus_cycle(20'h00000, 1'b1, 1'b0, 1'b1, 1, 16'hC0DE, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h01000, 1'b1, 1'b0, 1'b1, 1, 16'hDEAD, 1'b1, r2, r0, l2, l0);
        lit("miss_addr_rdy_low", 16'(l2), 16'd0);
        bus_cycle(20'h00000, 1'b0, 1'b0, 1'b1, 1, 16'hDEAD, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h00000, 1'b1, 1'b0, 1'b0, 1, 16'hDEAD, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h01000, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("miss_read_ad_o", r2, 16'h0000);
        bus_cycle(20'h00000, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("ram_after_misses", r2, 16'hC0DE);

        bus_cycle(20'h00030, 1'b1, 1'b0, 1'b1, 1, 16'h7777, 1'b1, r2, r0, l2, l0);
        ale = 1'b1; as_i = 4'h0; ad_i = 16'h0030; m_n = 1'b1; bhe_n = 1'b0; inta_n = 1'b1;
        step();
        idle_exp();
        ale = 1'b0; wr_n = 1'b0; ad_i = 16'h1111;
        step();
        exp_rdy[0] = 1'b0;
        rst = 1'b0;
        step();
        idle_exp();
        lit("reset_mid_rdy", {15'h0, bus_w2.rdy}, 16'h0001);
        lit("reset_mid_ad_oe", {15'h0, bus_w2.ad_oe}, 16'h0000);
        rst = 1'b1; wr_n = 1'b1;
        step();
        bus_cycle(20'h00030, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("reset_no_commit_wait2", r2, 16'h7777);
        lit("reset_no_commit_wait0", r0, 16'h7777);

        bus_cycle(20'h00040, 1'b1, 1'b0, 1'b1, 1, 16'h4444, 1'b1, r2, r0, l2, l0);
        bus_cycle(20'h00040, 1'b1, 1'b0, 1'b1, 2, 16'h9999, 1'b1, r2, r0, l2, l0);
        lit("proto_rdy_low", 16'(l2), 16'd0);
        bus_cycle(20'h00040, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b0, r2, r0, l2, l0);
        lit("proto_no_write", r2, 16'h4444);
        bus_cycle(20'h00010, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 1'b1, r2, r0, l2, l0);
        lit("ale_mid_done_wait2", r2, 16'hBEEF);
        lit("ale_mid_done_wait0", r0, 16'hBEEF);

        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
